// File: rtl/toggle_event_decoder_pkg.sv
// Shared constants and helpers for the toggle event decoder.
// Event indices follow the physical order of the tog_in lines.
package toggle_event_decoder_pkg;

    localparam int NUM_EVT      = 6;
    localparam int EVT_RESET    = 0;
    localparam int EVT_TEST     = 1;
    localparam int EVT_ENERGIA  = 2;
    localparam int EVT_MEDICINA = 3;
    localparam int EVT_FOT      = 4;
    localparam int EVT_ULT      = 5;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } out_state_e;

    // Lowest set index wins; bit 0 has the highest priority.
    function automatic logic [2:0] lowest_set(input logic [NUM_EVT-1:0] v);
        lowest_set = 3'd0;
        for (int i = NUM_EVT - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/toggle_event_decoder_sync.sv
// Per-line synchronizer plus change detector; emits a registered
// single-cycle detect pulse on either polarity of a level change.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_tmp,
    input  logic tog_in,
    output logic detect
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   det_q, det_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], tog_in};
        prev_d = sync_q[SYNC_STAGES-1];
        det_d  = sync_q[SYNC_STAGES-1] ^ prev_q;
    end

    always_ff @(posedge clk or negedge reset_tmp) begin
        if (!reset_tmp) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            det_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            det_q  <= det_d;
        end
    end

    assign detect = det_q;

endmodule

// File: rtl/toggle_event_decoder.sv
// Toggle event decoder: per-line detection feeds pending/overrun flags
// and a one-deep valid/ready output stage with fixed priority.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_EVT     = 6
) (
    input  logic               clk,
    input  logic               reset_tmp,
    input  logic [NUM_EVT-1:0] tog_in,
    input  logic               evt_ready,
    input  logic               clear_overrun,
    output logic               evt_valid,
    output logic [2:0]         evt_code,
    output logic [NUM_EVT-1:0] pending,
    output logic [NUM_EVT-1:0] overrun
);
    import toggle_event_decoder_pkg::*;

    logic [NUM_EVT-1:0] det;
    logic [NUM_EVT-1:0] pending_q, pending_d;
    logic [NUM_EVT-1:0] overrun_q, overrun_d;
    logic [NUM_EVT-1:0] take;
    logic [2:0]         code_q, code_d;
    out_state_e         state_q, state_d;

    for (genvar g = 0; g < NUM_EVT; g++) begin : g_sync
        toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk       (clk),
            .reset_tmp (reset_tmp),
            .tog_in    (tog_in[g]),
            .detect    (det[g])
        );
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        take    = '0;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    state_d = ST_PRESENT;
                    code_d  = lowest_set(pending_q);
                    take    = {{(NUM_EVT-1){1'b0}}, 1'b1} << code_d;
                end
            end
            ST_PRESENT: begin
                if (evt_ready) begin
                    if (|pending_q) begin
                        code_d = lowest_set(pending_q);
                        take   = {{(NUM_EVT-1){1'b0}}, 1'b1} << code_d;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A detect on a bit being loaded this edge re-arms it without loss.
        pending_d = (pending_q & ~take) | det;
        overrun_d = (clear_overrun ? '0 : overrun_q) | (det & pending_q & ~take);
    end

    always_ff @(posedge clk or negedge reset_tmp) begin
        if (!reset_tmp) begin
            state_q   <= ST_IDLE;
            code_q    <= 3'd0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign evt_valid = (state_q == ST_PRESENT);
    assign evt_code  = code_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Bench for toggle_event_decoder: directed scenarios then random traffic,
// checked against a sample-history reference model.
module tb_toggle_event_decoder;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset_tmp = 1'b0;
    logic [5:0] tog_in = '0;
    logic       evt_ready = 1'b0;
    logic       clear_overrun = 1'b0;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic [5:0] pending;
    logic [5:0] overrun;

    int ncmp = 0;
    int nfail = 0;

    logic [5:0] hist[$];
    logic [5:0] m_pend, m_ovr;
    logic       m_valid;
    logic [2:0] m_code;

    toggle_event_decoder #(.SYNC_STAGES(S), .NUM_EVT(6)) dut (
        .clk           (clk),
        .reset_tmp     (reset_tmp),
        .tog_in        (tog_in),
        .evt_ready     (evt_ready),
        .clear_overrun (clear_overrun),
        .evt_valid     (evt_valid),
        .evt_code      (evt_code),
        .pending       (pending),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S + 3; i++) hist.push_back(6'd0);
        m_pend  = '0;
        m_ovr   = '0;
        m_valid = 1'b0;
        m_code  = 3'd0;
    endtask

    // One rising edge of the reference: an event sampled at edge k lands in
    // pending at edge k+S+1, i.e. when it is S+1 samples old.
    task automatic model_edge();
        logic [5:0] det, took;
        int idx;
        hist.push_front(tog_in);
        det = hist[S+1] ^ hist[S+2];
        void'(hist.pop_back());
        took = '0;
        if ((!m_valid || evt_ready) && m_pend != 0) begin
            idx = 0;
            for (int i = 0; i < 6; i++) begin
                if (m_pend[i]) begin
                    idx = i;
                    break;
                end
            end
            took[idx] = 1'b1;
            m_code  = 3'(idx);
            m_valid = 1'b1;
        end else if (m_valid && evt_ready) begin
            m_valid = 1'b0;
        end
        m_ovr  = (clear_overrun ? 6'd0 : m_ovr) | (det & m_pend & ~took);
        m_pend = (m_pend & ~took) | det;
    endtask

    task automatic check_model(input string where);
        chk({where, ".valid"},   {7'd0, evt_valid}, {7'd0, m_valid});
        chk({where, ".code"},    {5'd0, evt_code},  {5'd0, m_code});
        chk({where, ".pending"}, {2'd0, pending},   {2'd0, m_pend});
        chk({where, ".overrun"}, {2'd0, overrun},   {2'd0, m_ovr});
    endtask

    task automatic step(input string where);
        @(posedge clk);
        model_edge();
        #1;
        check_model(where);
    endtask

    task automatic steps(input int n, input string where);
        for (int i = 0; i < n; i++) step(where);
    endtask

    // Assert reset away from a clock edge, check outputs cleared before any
    // edge arrives, then release just after an edge.
    task automatic do_reset(input string where);
        reset_tmp = 1'b0;
        model_reset();
        #1;
        chk({where, ".rst_valid"},   {7'd0, evt_valid}, 8'd0);
        chk({where, ".rst_code"},    {5'd0, evt_code},  8'd0);
        chk({where, ".rst_pending"}, {2'd0, pending},   8'd0);
        chk({where, ".rst_overrun"}, {2'd0, overrun},   8'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_tmp = 1'b1;
    endtask

    initial begin
        do_reset("init");

        // single event on bit 2
        steps(2, "idle");
        tog_in[2] = 1'b1;
        steps(5, "e2");
        chk("e2.valid", {7'd0, evt_valid}, 8'd1);
        chk("e2.code",  {5'd0, evt_code},  8'd2);
        evt_ready = 1'b1;
        step("e2hs");
        chk("e2hs.valid",   {7'd0, evt_valid}, 8'd0);
        chk("e2hs.pending", {2'd0, pending},   8'd0);

        // simultaneous 5,1,3 drained back-to-back
        tog_in = tog_in ^ 6'b101010;
        steps(4, "b2b");
        step("b2b1");
        chk("b2b.code1", {4'd0, evt_valid, evt_code}, 8'h09);
        step("b2b3");
        chk("b2b.code3", {4'd0, evt_valid, evt_code}, 8'h0b);
        step("b2b5");
        chk("b2b.code5", {4'd0, evt_valid, evt_code}, 8'h0d);
        step("b2bidle");
        chk("b2b.idle", {7'd0, evt_valid}, 8'd0);

        // stall on code 0, overrun on bit 4, clear it
        evt_ready = 1'b0;
        tog_in[0] = ~tog_in[0];
        steps(5, "stall0");
        chk("stall0.code", {4'd0, evt_valid, evt_code}, 8'h08);
        tog_in[4] = ~tog_in[4];
        steps(10, "ovr4a");
        tog_in[4] = ~tog_in[4];
        steps(6, "ovr4b");
        chk("ovr4.pending", {7'd0, pending[4]}, 8'd1);
        chk("ovr4.overrun", {7'd0, overrun[4]}, 8'd1);
        clear_overrun = 1'b1;
        step("clr");
        clear_overrun = 1'b0;
        chk("clr.overrun", {2'd0, overrun}, 8'd0);

        // re-event on the held code: pending without overrun
        tog_in[0] = ~tog_in[0];
        steps(5, "held0");
        chk("held0.pending", {7'd0, pending[0]}, 8'd1);
        chk("held0.overrun", {7'd0, overrun[0]}, 8'd0);
        evt_ready = 1'b1;
        step("hs1");
        chk("hs1.code0again", {4'd0, evt_valid, evt_code}, 8'h08);
        step("hs2");
        chk("hs2.code4", {4'd0, evt_valid, evt_code}, 8'h0c);
        step("hs3");

        // async reset while presenting with pending 100100
        evt_ready = 1'b0;
        tog_in = tog_in ^ 6'b100101;
        steps(5, "pre_rst");
        chk("pre_rst.pending", {2'd0, pending}, 8'h24);
        chk("pre_rst.valid",   {7'd0, evt_valid}, 8'd1);
        #2;
        tog_in = '0;
        do_reset("midhs");
        for (int i = 0; i < 8; i++) begin
            step("post_rst");
            chk("post_rst.quiet", {1'b0, evt_valid, pending}, 8'd0);
        end

        // tog_in[1] held high through reset: exactly one event
        #2;
        tog_in = 6'b000010;
        do_reset("held1");
        steps(6, "held1");
        chk("held1.code", {4'd0, evt_valid, evt_code}, 8'h09);
        evt_ready = 1'b1;
        step("held1hs");
        for (int i = 0; i < 6; i++) begin
            step("held1after");
            chk("held1.once", {1'b0, evt_valid, pending}, 8'd0);
        end

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) tog_in[$urandom_range(0, 5)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) tog_in = tog_in ^ 6'($urandom);
            evt_ready     = (n % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clear_overrun = ($urandom_range(0, 19) == 0);
            if (n % 400 == 399) begin
                #2;
                tog_in = 6'($urandom);
                do_reset("rnd_rst");
            end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/toggle_event_decoder.md
TOGGLE_EVENT_DECODER -- requirements
Module: toggle_event_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops per toggle input; legal range 2..4.
REQ-002 Parameter NUM_EVT, default 6: number of toggle inputs; fixed at 6 for this release.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_tmp  input  1  reset, asynchronous, active-low.
REQ-005 tog_in  input  6  level-toggle event lines: bit0 reset, bit1 test, bit2 energia, bit3 medicina, bit4 fotocelda, bit5 ultrasonido; each change of level is one event.
REQ-006 evt_ready  input  1  consumer accepts the presented event this cycle.
REQ-007 clear_overrun  input  1  single-cycle request to clear all overrun flags.
REQ-008 evt_valid  output  1  an event is presented on evt_code.
REQ-009 evt_code  output  3  index 0..5 of the presented event.
REQ-010 pending  output  6  per-event flags, detected but not yet presented.
REQ-011 overrun  output  6  sticky per-event flags: an event was lost.

Function
REQ-012 Each tog_in bit SHALL pass through SYNC_STAGES flops; an event is detected when the synchronized value differs from its previous registered value (either polarity).
REQ-013 A detected event SHALL set its pending bit at the next edge.
REQ-014 Latency: a tog_in change first sampled at edge k SHALL set pending at edge k+SYNC_STAGES+1 and, if the output stage is free, assert evt_valid at edge k+SYNC_STAGES+2.
REQ-015 Output FSM has two states: IDLE (evt_valid=0) and PRESENT (evt_valid=1).
REQ-016 IDLE -> PRESENT when any pending bit is set; load the lowest-index set bit into evt_code and clear that pending bit on the same edge.
REQ-017 PRESENT with evt_ready=1 is a handshake: if pending is nonzero, reload the next lowest index in the same edge and stay in PRESENT (back-to-back events, no bubble); otherwise go to IDLE.
REQ-018 PRESENT with evt_ready=0: evt_code and evt_valid SHALL hold stable.
REQ-019 evt_ready while IDLE SHALL be ignored.
REQ-020 Detection on a bit whose pending flag is already set SHALL set its overrun bit; pending remains 1 (events coalesce).
REQ-021 Detection on a bit in the same cycle that bit is loaded into the output SHALL leave pending=1 with no overrun.
REQ-022 A detection on the event currently held in evt_code (not pending) SHALL set pending and not overrun.
REQ-023 clear_overrun clears all overrun bits; a simultaneous new overrun on a bit wins for that bit.
REQ-024 Priority is fixed: bit0 highest, bit5 lowest; no fairness is required.

Reset
REQ-025 reset_tmp low SHALL immediately force: all synchronizer and previous-value flops 0, pending 0, overrun 0, evt_valid 0, evt_code 0, FSM IDLE.
REQ-026 Deassertion is synchronized externally. The first edges after release SHALL NOT generate events unless tog_in changes or is already 1. A tog_in held at 1 through reset yields exactly one event.
REQ-027 Reset asserted mid-handshake SHALL drop the presented event and all pending events, with no partial output.

Structure
REQ-028 A shared package SHALL hold NUM_EVT and event-index constants EVT_RESET=0, EVT_TEST=1, EVT_ENERGIA=2, EVT_MEDICINA=3, EVT_FOT=4, EVT_ULT=5.
REQ-029 Sub-module toggle_sync (one instance per bit) SHALL contain the synchronizer and change detector. It outputs a single-cycle detect pulse.
REQ-030 The priority encoder, pending/overrun registers and FSM reside in the top module.

Verification
REQ-031 Reset, then tog_in[2] 0->1 -> after 4 edges evt_valid=1, evt_code=2; with evt_ready=1 for one cycle -> evt_valid=0, pending=0.
REQ-032 tog_in bits 5, 1 and 3 toggle in the same cycle with evt_ready held 1 -> codes 1, 3, 5 on consecutive cycles, then IDLE.
REQ-033 With evt_ready=0, tog_in[4] toggles twice, 10 cycles apart -> pending[4]=1, overrun[4]=1; one pulse of clear_overrun -> overrun=0.
REQ-034 evt_code=0 presented and stalled; tog_in[0] toggles again -> pending[0]=1, overrun[0]=0; after two handshakes, code 0 is seen twice.
REQ-035 reset_tmp pulsed low while evt_valid=1 and pending=6'b100100 -> all outputs 0 asynchronously; no events after release with tog_in stable at 0.
REQ-036 tog_in[1] held at 1 across reset release -> exactly one event with code 1.
